// File: rtl/au_bcd_unit.sv
// Calculator arithmetic unit: operand registers A/B, add/subtract result R, and a
// sequential double-dabble converter that feeds BCD digits and a sign to the display.
module au_bcd_unit #(
  parameter int DW = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Reset,
  input  logic            LoadA,
  input  logic            LoadB,
  input  logic            LoadR,
  input  logic            AS,
  input  logic            IUAU,
  input  logic [DW-1:0]   din,
  output logic [4*ND-1:0] digits,
  output logic            neg,
  output logic [DW:0]     r_bin,
  output logic            busy,
  output logic            done
);

  localparam int W  = DW + 1;
  localparam int SW = 4 * ND + W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t          state, stateNext;
  logic [DW-1:0]   a, b, lastDin;
  logic [DW:0]     r, srcVal, pendVal, rCalc, reqVal;
  logic            srcNeg, pendNeg, pendValid, pendIsR, negCalc, reqNeg;
  logic [SW-1:0]   shreg, shAdj, shNext;
  logic [CW-1:0]   cnt;
  logic            reqR, reqD, req, lastShift;
  logic            startNew, startPend, toPend, keepPend;

  // Result of the operation on the pre-edge operands, and the start requests it can raise
  always_comb begin
    rCalc   = {1'b0, a} + {1'b0, b};
    negCalc = 1'b0;
    if (AS) begin
      negCalc = (a < b);
      rCalc   = (a < b) ? {1'b0, b - a} : {1'b0, a - b};
    end
    reqR      = LoadR;
    reqD      = IUAU && (din != lastDin) && !LoadR;
    req       = reqR || reqD;
    reqVal    = reqR ? rCalc : {1'b0, din};
    reqNeg    = reqR ? negCalc : 1'b0;
    lastShift = (state == SHIFT) && (cnt == CW'(W - 1));
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift left one bit
  always_comb begin
    shAdj = shreg;
    for (int i = 0; i < ND; i++) begin
      if (shreg[W+4*i +: 4] >= 4'd5)
        shAdj[W+4*i +: 4] = shreg[W+4*i +: 4] + 4'd3;
    end
    shNext = {shAdj[SW-2:0], 1'b0};
  end

  // Next state; a waiting pending request always starts before a fresh one
  always_comb begin
    stateNext = state;
    startNew  = 1'b0;
    startPend = 1'b0;
    case (state)
      IDLE: begin
        if (pendValid) begin
          startPend = 1'b1;
          stateNext = LOAD;
        end else if (req) begin
          startNew  = 1'b1;
          stateNext = LOAD;
        end
      end
      LOAD:    stateNext = SHIFT;
      SHIFT:   if (lastShift) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (Reset) stateNext = IDLE;
    toPend   = req && !startNew;
    keepPend = pendValid && pendIsR && !reqR && !startPend;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= '0; b <= '0; r <= '0; lastDin <= '0;
      srcVal <= '0; srcNeg <= 1'b0;
      pendValid <= 1'b0; pendIsR <= 1'b0; pendVal <= '0; pendNeg <= 1'b0;
      shreg <= '0; cnt <= '0;
      digits <= '0; neg <= 1'b0; done <= 1'b0;
    end else if (Reset) begin
      a <= '0; b <= '0; r <= '0; lastDin <= '0;
      srcVal <= '0; srcNeg <= 1'b0;
      pendValid <= 1'b0; pendIsR <= 1'b0; pendVal <= '0; pendNeg <= 1'b0;
      shreg <= '0; cnt <= '0;
      digits <= '0; neg <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (LoadA) a <= din;
      if (LoadB) b <= din;
      if (LoadR) r <= rCalc;
      if (reqD)  lastDin <= din;

      if (startNew) begin
        srcVal <= reqVal;
        srcNeg <= reqNeg;
      end else if (startPend) begin
        srcVal <= pendVal;
        srcNeg <= pendNeg;
      end

      // A pending LoadR is only displaced by a newer LoadR
      if (toPend && !keepPend) begin
        pendValid <= 1'b1;
        pendIsR   <= reqR;
        pendVal   <= reqVal;
        pendNeg   <= reqNeg;
      end else if (startPend) begin
        pendValid <= 1'b0;
      end

      if (state == LOAD) begin
        shreg <= {{(4*ND){1'b0}}, srcVal};
        cnt   <= '0;
      end else if (state == SHIFT) begin
        shreg <= shNext;
        cnt   <= cnt + CW'(1);
        if (lastShift) begin
          digits <= shNext[SW-1 -: 4*ND];
          neg    <= srcNeg;
          done   <= 1'b1;
        end
      end
    end
  end

  assign busy  = (state != IDLE);
  assign r_bin = r;

endmodule
